// File: rtl/discrete_audio_pkg.sv
// Shared types, constants and the output saturation helper for the discrete
// sound generator audio path.
package discrete_audio_pkg;

    typedef logic [15:0]        sample_u_t;
    typedef logic signed [15:0] sample_s_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        FILTER,
        OUTPUT
    } mixer_state_t;

    localparam int         SAT_MAX    = 32767;
    localparam int         SAT_MIN    = -32768;
    localparam logic [7:0] GAIN_UNITY = 8'h80;

    // Signed width of the filter datapath: 20-bit unsigned mix plus a sign bit.
    localparam int FILT_W = 21;

    function automatic sample_s_t sat16(input logic signed [FILT_W-1:0] v);
        if (v > FILT_W'(SAT_MAX)) begin
            sat16 = sample_s_t'(SAT_MAX);
        end else if (v < FILT_W'(SAT_MIN)) begin
            sat16 = sample_s_t'(SAT_MIN);
        end else begin
            sat16 = v[15:0];
        end
    endfunction

endpackage

// File: rtl/discrete_mixer_dc_blocker.sv
// One-pole DC blocker: y = x - avg, where avg leaks toward x by 2^-DC_SHIFT
// per update. avg keeps DC_SHIFT fraction bits so small offsets still decay.
module dc_blocker
    import discrete_audio_pkg::*;
#(
    parameter int DC_SHIFT = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic signed [FILT_W-1:0]   x,
    output logic signed [FILT_W-1:0]   y,
    output logic signed [20+DC_SHIFT-1:0] avg
);

    localparam int AVG_W = 20 + DC_SHIFT;

    logic signed [AVG_W-1:0] avg_next;

    generate
        if (DC_SHIFT == 0) begin : g_bypass
            assign y        = x;
            assign avg_next = '0;
        end else begin : g_block
            localparam int DIFF_W = FILT_W + DC_SHIFT + 1;

            logic signed [DIFF_W-1:0] diff;
            logic signed [DIFF_W-1:0] step;
            logic signed [FILT_W-1:0] avg_int;

            // Both operands are aligned to the fractional scale of avg.
            assign diff     = (DIFF_W'(x) <<< DC_SHIFT) - DIFF_W'(avg);
            assign step     = diff >>> DC_SHIFT;
            assign avg_next = avg + AVG_W'(step);
            assign avg_int  = FILT_W'(avg >>> DC_SHIFT);
            assign y        = x - avg_int;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            avg <= '0;
        end else if (en) begin
            avg <= avg_next;
        end
    end

endmodule

// File: rtl/discrete_mixer.sv
// Time-multiplexed gain/sum mixer for the discrete sound channels, followed
// by a DC blocker and signed 16-bit saturation.
module discrete_mixer
    import discrete_audio_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int GAIN_W   = 8,
    parameter int DC_SHIFT = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clk_48KHz_en,
    input  logic [NUM_CH*16-1:0]     ch_in,
    input  logic [NUM_CH*GAIN_W-1:0] ch_gain,
    input  logic                     mute,
    output logic [15:0]              audio_out,
    output logic                     sample_valid,
    output logic                     overrun
);

    localparam int CNT_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int ACC_W  = 16 + GAIN_W + $clog2(NUM_CH);
    localparam int PROD_W = 16 + GAIN_W;

    mixer_state_t              state;
    logic [CNT_W-1:0]          cnt;
    logic [ACC_W-1:0]          acc;
    logic [NUM_CH*16-1:0]      ch_r;
    logic [NUM_CH*GAIN_W-1:0]  gain_r;

    sample_u_t                 ch_cur;
    logic [GAIN_W-1:0]         gain_cur;
    logic [PROD_W-1:0]         prod;
    logic [ACC_W-1:0]          acc_sh;
    logic                      last_ch;
    logic signed [FILT_W-1:0]  filt_x;
    logic signed [FILT_W-1:0]  filt_y;
    logic signed [20+DC_SHIFT-1:0] dc_avg_unused;

    // The snapshot registers shift down one channel per ACCUM cycle, so the
    // current channel is always in the low slice.
    assign ch_cur   = ch_r[15:0];
    assign gain_cur = gain_r[GAIN_W-1:0];
    assign prod     = PROD_W'(ch_cur) * PROD_W'(gain_cur);
    assign acc_sh   = acc >> 7;
    assign filt_x   = FILT_W'(acc_sh);
    assign last_ch  = (cnt == CNT_W'(NUM_CH - 1));

    dc_blocker #(
        .DC_SHIFT(DC_SHIFT)
    ) u_dc_blocker (
        .clk   (clk),
        .reset (reset),
        .en    (state == FILTER),
        .x     (filt_x),
        .y     (filt_y),
        .avg   (dc_avg_unused)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            acc          <= '0;
            ch_r         <= '0;
            gain_r       <= '0;
            audio_out    <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (clk_48KHz_en && (state != IDLE)) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (clk_48KHz_en) begin
                        ch_r   <= ch_in;
                        gain_r <= ch_gain;
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= ACCUM;
                    end
                end
                ACCUM: begin
                    acc    <= acc + ACC_W'(prod);
                    ch_r   <= ch_r >> 16;
                    gain_r <= gain_r >> GAIN_W;
                    cnt    <= cnt + CNT_W'(1);
                    if (last_ch) begin
                        state <= FILTER;
                    end
                end
                FILTER: begin
                    // Registered here so the new sample is visible during OUTPUT.
                    audio_out    <= mute ? 16'h0000 : sat16(filt_y);
                    sample_valid <= 1'b1;
                    state        <= OUTPUT;
                end
                OUTPUT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_discrete_mixer.sv
// Scoreboard bench for discrete_mixer: three instances (DC_SHIFT 8, 0, 2)
// share one stimulus stream and are checked against a reference model.
module tb_discrete_mixer;
    import discrete_audio_pkg::*;

    localparam int NUM_CH = 4;
    localparam int GAIN_W = 8;
    localparam int LAT    = NUM_CH + 2;
    localparam int PERIOD = NUM_CH + 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        strobe = 1'b0;
    logic        mute = 1'b0;
    logic [63:0] ch_in = '0;
    logic [31:0] ch_gain = '0;

    logic [15:0] out8, out0, out2;
    logic        v8, v0, v2;
    logic        ov8, ov0, ov2;

    int vectors = 0;
    int miscompares = 0;

    longint avg8 = 0;
    longint avg0 = 0;
    longint avg2 = 0;
    logic [15:0] exp8_q[$];
    logic [15:0] exp0_q[$];
    logic [15:0] exp2_q[$];

    always #5 clk = ~clk;

    discrete_mixer #(.NUM_CH(NUM_CH), .GAIN_W(GAIN_W), .DC_SHIFT(8)) u_d8 (
        .clk(clk), .reset(reset), .clk_48KHz_en(strobe), .ch_in(ch_in),
        .ch_gain(ch_gain), .mute(mute), .audio_out(out8), .sample_valid(v8),
        .overrun(ov8));

    discrete_mixer #(.NUM_CH(NUM_CH), .GAIN_W(GAIN_W), .DC_SHIFT(0)) u_d0 (
        .clk(clk), .reset(reset), .clk_48KHz_en(strobe), .ch_in(ch_in),
        .ch_gain(ch_gain), .mute(mute), .audio_out(out0), .sample_valid(v0),
        .overrun(ov0));

    discrete_mixer #(.NUM_CH(NUM_CH), .GAIN_W(GAIN_W), .DC_SHIFT(2)) u_d2 (
        .clk(clk), .reset(reset), .clk_48KHz_en(strobe), .ch_in(ch_in),
        .ch_gain(ch_gain), .mute(mute), .audio_out(out2), .sample_valid(v2),
        .overrun(ov2));

    // Reference: exact mix, leaky average with `shift` fraction bits, clamp, mute.
    function automatic logic [15:0] model(input int shift, input longint avg_in,
                                          output longint avg_out);
        longint acc, x, y;
        acc = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            acc += longint'(ch_in[16*k +: 16]) * longint'(ch_gain[GAIN_W*k +: GAIN_W]);
        end
        x = acc >>> 7;
        if (shift == 0) begin
            y = x;
            avg_out = avg_in;
        end else begin
            y = x - (avg_in >>> shift);
            avg_out = avg_in + (((x <<< shift) - avg_in) >>> shift);
        end
        if (mute) model = 16'h0000;
        else if (y > 32767) model = 16'h7FFF;
        else if (y < -32768) model = 16'h8000;
        else model = y[15:0];
    endfunction

    task automatic push_expect();
        longint n;
        exp8_q.push_back(model(8, avg8, n)); avg8 = n;
        exp0_q.push_back(model(0, avg0, n)); avg0 = n;
        exp2_q.push_back(model(2, avg2, n)); avg2 = n;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        avg8 = 0; avg0 = 0; avg2 = 0;
        exp8_q.delete(); exp0_q.delete(); exp2_q.delete();
    endtask

    // Drives one strobe, waits for the result and scores it against the queue.
    task automatic run_sample(output int lat, output logic [15:0] g8,
                              output logic [15:0] g0, output logic [15:0] g2);
        bit found;
        logic [15:0] e8, e0, e2;
        @(negedge clk);
        strobe = 1'b1;
        push_expect();
        lat = 0;
        found = 1'b0;
        for (int i = 0; i < 4*PERIOD && !found; i++) begin
            @(negedge clk);
            strobe = 1'b0;
            lat++;
            found = v8 | v0 | v2;
        end
        g8 = out8; g0 = out0; g2 = out2;
        e8 = exp8_q.pop_front(); e0 = exp0_q.pop_front(); e2 = exp2_q.pop_front();
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL sample_timeout: no sample_valid within %0d cycles", 4*PERIOD);
        end else begin
            if ({v8, v0, v2} !== 3'b111) begin
                miscompares++;
                $display("FAIL valid_align: valid=%b required 111", {v8, v0, v2});
            end
            vectors += 3;
            if (g8 !== e8) begin
                miscompares++;
                $display("FAIL out_shift8: got %0d required %0d", $signed(g8), $signed(e8));
            end
            if (g0 !== e0) begin
                miscompares++;
                $display("FAIL out_shift0: got %0d required %0d", $signed(g0), $signed(e0));
            end
            if (g2 !== e2) begin
                miscompares++;
                $display("FAIL out_shift2: got %0d required %0d", $signed(g2), $signed(e2));
            end
            @(negedge clk);
            vectors++;
            if ({v8, v0, v2} !== 3'b000) begin
                miscompares++;
                $display("FAIL valid_width: valid=%b one cycle later, required 000", {v8, v0, v2});
            end
        end
        repeat ($urandom_range(0, 5)) @(negedge clk);
    endtask

    task automatic test_reset();
        int lat;
        bit seen;
        logic [15:0] g8, g0, g2;
        vectors++;
        if ({out8, out0, out2, v8, v0, v2, ov8, ov0, ov2} !== '0) begin
            miscompares++;
            $display("FAIL reset_state: out=%h/%h/%h valid=%b ovr=%b required all zero",
                     out8, out0, out2, {v8, v0, v2}, {ov8, ov0, ov2});
        end
        ch_in = 64'h0000_0000_0000_4000;
        ch_gain = {4{GAIN_UNITY}};
        run_sample(lat, g8, g0, g2);
        // Strobe, reset two cycles into ACCUM with a coincident strobe.
        @(negedge clk); strobe = 1'b1;
        @(negedge clk); strobe = 1'b0;
        @(negedge clk); reset = 1'b1; strobe = 1'b1;
        @(negedge clk); reset = 1'b0; strobe = 1'b0;
        avg8 = 0; avg0 = 0; avg2 = 0;
        vectors++;
        if ({out8, out0, out2, v8, v0, v2, ov8, ov0, ov2} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_accum: out=%h/%h/%h valid=%b ovr=%b required all zero",
                     out8, out0, out2, {v8, v0, v2}, {ov8, ov0, ov2});
        end
        seen = 1'b0;
        repeat (3*PERIOD) begin
            @(negedge clk);
            if (v8 | v0 | v2) seen = 1'b1;
        end
        vectors++;
        if (seen) begin
            miscompares++;
            $display("FAIL reset_abandon: sample_valid seen=1 after reset, required 0");
        end
    endtask

    task automatic test_dc_step();
        int lat;
        logic [15:0] g8, g0, g2, prev8;
        do_reset();
        ch_in = 64'h0000_0000_0000_4000;
        ch_gain = {4{GAIN_UNITY}};
        run_sample(lat, g8, g0, g2);
        vectors += 2;
        if (lat != LAT) begin
            miscompares++;
            $display("FAIL latency: got %0d cycles required %0d", lat, LAT);
        end
        if (g8 !== 16'd16384) begin
            miscompares++;
            $display("FAIL dc_step_first: got %0d required 16384", $signed(g8));
        end
        run_sample(lat, g8, g0, g2);
        vectors++;
        if (g8 !== 16'd16320) begin
            miscompares++;
            $display("FAIL dc_step_second: got %0d required 16320", $signed(g8));
        end
        for (int i = 0; i < 6; i++) begin
            prev8 = g8;
            run_sample(lat, g8, g0, g2);
            vectors++;
            if (!($signed(g8) < $signed(prev8) && $signed(g8) >= 0)) begin
                miscompares++;
                $display("FAIL dc_decay: got %0d after %0d, required 0 <= next < previous",
                         $signed(g8), $signed(prev8));
            end
        end
    endtask

    task automatic test_saturation();
        int lat;
        logic [15:0] g8, g0, g2;
        do_reset();
        ch_in = {4{16'hFFFF}};
        ch_gain = {4{8'hFF}};
        run_sample(lat, g8, g0, g2);
        vectors++;
        if (g0 !== 16'h7FFF) begin
            miscompares++;
            $display("FAIL pos_sat: got %0d required 32767", $signed(g0));
        end
        for (int i = 0; i < 60; i++) run_sample(lat, g8, g0, g2);
        ch_in = '0;
        ch_gain = '0;
        run_sample(lat, g8, g0, g2);
        vectors++;
        if (g2 !== 16'h8000) begin
            miscompares++;
            $display("FAIL neg_sat: got %0d required -32768", $signed(g2));
        end
    endtask

    task automatic test_mute();
        int lat;
        logic [15:0] g8, g0, g2;
        do_reset();
        ch_in = 64'h0000_0000_0000_2000;
        ch_gain = {4{GAIN_UNITY}};
        mute = 1'b1;
        for (int i = 0; i < 10; i++) begin
            run_sample(lat, g8, g0, g2);
            vectors++;
            if ({g8, g0, g2} !== '0) begin
                miscompares++;
                $display("FAIL mute_zero: got %h/%h/%h required 0", g8, g0, g2);
            end
        end
        mute = 1'b0;
        run_sample(lat, g8, g0, g2);
        vectors += 2;
        if (g8 === 16'd8192) begin
            miscompares++;
            $display("FAIL unmute_tracking: got %0d, required a value below 8192", $signed(g8));
        end
        if (g0 !== 16'd8192) begin
            miscompares++;
            $display("FAIL unmute_bypass: got %0d required 8192", $signed(g0));
        end
    endtask

    task automatic test_back_to_back();
        int pulses, last;
        logic exp_ov;
        logic [15:0] e8, e0, e2;
        do_reset();
        ch_in = {16'h0800, 16'h3000, 16'h1234, 16'h1000};
        ch_gain = {8'h40, 8'hC0, 8'h80, 8'h20};
        pulses = 0;
        last = 0;
        @(negedge clk);
        strobe = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            exp_ov = (c >= 2);
            vectors++;
            if ({ov8, ov0, ov2} !== {3{exp_ov}}) begin
                miscompares++;
                $display("FAIL overrun_cycle%0d: got %b required %b", c, {ov8, ov0, ov2}, {3{exp_ov}});
            end
            if (v8) begin
                pulses++;
                push_expect();
                e8 = exp8_q.pop_front(); e0 = exp0_q.pop_front(); e2 = exp2_q.pop_front();
                vectors += 2;
                if (c != ((pulses == 1) ? LAT : last + PERIOD)) begin
                    miscompares++;
                    $display("FAIL pulse_spacing: pulse %0d at cycle %0d, previous %0d, period %0d",
                             pulses, c, last, PERIOD);
                end
                if ({out8, out0, out2} !== {e8, e0, e2}) begin
                    miscompares++;
                    $display("FAIL b2b_out: got %h/%h/%h required %h/%h/%h",
                             out8, out0, out2, e8, e0, e2);
                end
                last = c;
            end
        end
        strobe = 1'b0;
        vectors++;
        if (pulses != 5) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d pulses required 5", pulses);
        end
        repeat (PERIOD) @(negedge clk);
        vectors++;
        if ({ov8, ov0, ov2} !== 3'b111) begin
            miscompares++;
            $display("FAIL overrun_sticky: got %b required 111", {ov8, ov0, ov2});
        end
        do_reset();
        vectors++;
        if ({ov8, ov0, ov2} !== 3'b000) begin
            miscompares++;
            $display("FAIL overrun_clear: got %b required 000", {ov8, ov0, ov2});
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_dc_step();
        test_saturation();
        test_mute();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/discrete_mixer.md
Name: discrete_mixer

Overview:
Downstream stage for the discrete sound generators (bonus, walk, jump, etc.). It consumes their unsigned 16-bit audio outputs on each 48 kHz sample enable. Each channel is scaled by a per-channel gain and summed in a time-multiplexed MAC. The sum then passes through a one-pole DC blocker and is saturated to a signed 16-bit sample for the platform audio output.

Parameters:
NUM_CH, 4, number of input channels (1..8)
GAIN_W, 8, gain width; unsigned Q1.7, so 0x80 = 1.0 and 0xFF = 1.99
DC_SHIFT, 8, DC blocker time-constant shift; 0 = blocker bypassed

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
clk_48KHz_en  in  1  one-cycle sample strobe
ch_in  in  NUM_CH*16  unsigned channel samples; channel k at [16k+15:16k]
ch_gain  in  NUM_CH*GAIN_W  per-channel gains, same packing as ch_in
mute  in  1  force output to zero
audio_out  out  16  signed mixed sample
sample_valid  out  1  one-cycle pulse when audio_out updates
overrun  out  1  sticky: a strobe arrived while busy

Behaviour:
- Clock and reset
  - Single clock domain, clk.
  - reset is synchronous and active-high.
- Reset values
  - audio_out = 0, sample_valid = 0, overrun = 0.
  - Accumulator = 0, DC average = 0, state = IDLE, channel counter = 0.
- FSM: IDLE -> ACCUM -> FILTER -> OUTPUT -> IDLE.
- IDLE
  - On clk_48KHz_en: snapshot ch_in and ch_gain into registers, clear the accumulator, go to ACCUM.
- ACCUM (NUM_CH cycles, channel counter 0..NUM_CH-1)
  - Each cycle: acc += ch_in[k] * ch_gain[k].
  - Each product is 24-bit unsigned; acc is 16+GAIN_W+clog2(NUM_CH) bits unsigned and cannot overflow.
  - After the last channel, go to FILTER.
- FILTER (1 cycle)
  - x = acc >> 7, unsigned, zero-extended into the signed filter datapath.
  - If DC_SHIFT > 0:
    - y = x - avg.
    - avg_next = avg + ((x - avg) >>> DC_SHIFT), arithmetic shift.
    - avg has 20 integer bits plus DC_SHIFT fraction bits and is held signed.
  - If DC_SHIFT == 0: y = x, and avg is unused.
- OUTPUT (1 cycle)
  - audio_out = sat16(y), clamping to the range [-32768, 32767].
  - audio_out = 0 if mute is high.
  - Pulse sample_valid high for this one cycle, then return to IDLE.
- Latency: strobe at cycle T gives sample_valid at cycle T+NUM_CH+2. audio_out holds between updates.
- Strobe while not in IDLE
  - The strobe is dropped and overrun is set to 1.
  - overrun stays set until reset.
  - The in-flight sample completes unaffected.
- mute only gates the OUTPUT stage. The DC average keeps tracking, so unmuting causes no DC step.
- Inputs change only at the snapshot; changes during ACCUM are ignored.
- Reset mid-operation abandons the sample with no sample_valid pulse; all state returns to reset values next cycle.
- Strobe in the same cycle as reset: reset wins and the strobe is ignored.

Decomposition:
- Package discrete_audio_pkg holds:
  - sample_u_t (16-bit unsigned) and sample_s_t (16-bit signed).
  - mixer_state_t enum {IDLE, ACCUM, FILTER, OUTPUT}.
  - Constants SAT_MAX = 32767, SAT_MIN = -32768, GAIN_UNITY = 8'h80.
  - A sat16 function.
- Sub-module dc_blocker (parameter DC_SHIFT):
  - Inputs: clk, reset, en, x.
  - Outputs: y and avg state.
  - Combinational y with registered avg update on en.
  - Instantiated once and driven by the FILTER state.

Test Plan:
- Reset and idle: assert reset during ACCUM -> no sample_valid; audio_out = 0, overrun = 0 on the following cycle.
- Single-channel DC step: NUM_CH = 4, DC_SHIFT = 8, ch0 = 0x4000 with gain 0x80, others 0; strobe every 1000 cycles.
  - Sample 1: audio_out = 16384, sample_valid exactly 6 cycles after the strobe.
  - Sample 2: 16320.
  - Later samples decay monotonically toward 0.
- Positive saturation: all channels 0xFFFF, gains 0xFF, DC_SHIFT = 0 -> audio_out = 32767.
- Negative saturation: settle with all channels 0xFFFF, gains 0xFF, DC_SHIFT = 2, then drive all inputs to 0.
  - Next sample = -32768.
- Mute: ch0 = 0x2000 with gain 0x80, mute = 1 for 10 samples, then mute = 0.
  - Outputs are 0 while muted.
  - First unmuted sample equals the unmuted reference model value (avg advanced 10 times), not 8192.
- Overrun: clk_48KHz_en tied high continuously.
  - sample_valid pulses every NUM_CH+3 cycles.
  - overrun = 1 from the second cycle onward and stays set until reset.
